// File: rtl/enc_tuner_pkg.sv
// Shared defaults and quadrature helpers for the encoder tuning-word block.
package enc_tuner_pkg;

  localparam int DEF_TW_WIDTH    = 16;
  localparam int DEF_FILTER_LEN  = 4;
  localparam int DEF_FINE_STEP   = 1;
  localparam int DEF_COARSE_STEP = 64;
  localparam int DEF_TW_MIN      = 1;
  localparam int DEF_TW_MAX      = 'hFFF0;
  localparam int DEF_TW_RESET    = 256;

  // Gray-coded {A,B} states in clockwise order.
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DN      = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // Position of a Gray state around the clockwise cycle (0..3).
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    logic [1:0] p;
    case (g)
      GRAY_S0: p = 2'd0;
      GRAY_S1: p = 2'd1;
      GRAY_S2: p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // Classify the move from prev to cur by the modulo-4 position distance:
  // 1 is a clockwise quarter step, 3 is counter-clockwise, 2 means both bits flipped.
  function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    step_t      s;
    d = gray_pos(cur) - gray_pos(prev);
    case (d)
      2'd0:    s = STEP_NONE;
      2'd1:    s = STEP_UP;
      2'd2:    s = STEP_ILLEGAL;
      default: s = STEP_DN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Single-channel glitch filter: output follows the input only after the input
// has disagreed with it on FILTER_LEN consecutive clocks.
module enc_glitch_filter
  import enc_tuner_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int              CW   = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]   LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt;

  // Count the mismatch run; flip on its last clock, clear on any agreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= raw;
      cnt  <= '0;
    end else if (raw != filt) begin
      if (cnt == LAST) begin
        filt <= raw;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/enc_tuner.sv
// Rotary-encoder tuner: filters A/B, decodes quadrature into detents and
// steps a saturating tuning word for the downstream NCO.
module enc_tuner
  import enc_tuner_pkg::*;
#(
  parameter int TW_WIDTH    = DEF_TW_WIDTH,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int FINE_STEP   = DEF_FINE_STEP,
  parameter int COARSE_STEP = DEF_COARSE_STEP,
  parameter int TW_MIN      = DEF_TW_MIN,
  parameter int TW_MAX      = DEF_TW_MAX,
  parameter int TW_RESET    = DEF_TW_RESET
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic                sA,
  input  logic                sB,
  output logic [TW_WIDTH-1:0] tw,
  output logic                tw_valid,
  output logic                dir,
  output logic                err
);

  localparam int XW = TW_WIDTH + 1;

  localparam logic [XW-1:0]       FINE_X   = XW'(FINE_STEP);
  localparam logic [XW-1:0]       COARSE_X = XW'(COARSE_STEP);
  localparam logic [XW-1:0]       MIN_X    = XW'(TW_MIN);
  localparam logic [XW-1:0]       MAX_X    = XW'(TW_MAX);
  localparam logic [TW_WIDTH-1:0] MIN_TW   = TW_WIDTH'(TW_MIN);
  localparam logic [TW_WIDTH-1:0] MAX_TW   = TW_WIDTH'(TW_MAX);
  localparam logic [TW_WIDTH-1:0] RESET_TW = TW_WIDTH'(TW_RESET);

  // Filtered channels
  logic filt_a;
  logic filt_b;
  logic [1:0] cur_ab;

  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (sA),
    .filt  (filt_a)
  );

  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (sB),
    .filt  (filt_b)
  );

  assign cur_ab = {filt_a, filt_b};

  // Decode / detent stage
  logic [1:0]        prev_ab;
  logic signed [3:0] phase;
  logic signed [3:0] phase_sum;
  logic              det_up;
  logic              det_dn;
  step_t             step;

  // Classify this cycle's filtered transition and form the candidate count.
  always_comb begin
    step      = quad_step(prev_ab, cur_ab);
    phase_sum = phase;
    case (step)
      STEP_UP: phase_sum = phase + 4'sd1;
      STEP_DN: phase_sum = phase - 4'sd1;
      default: phase_sum = phase;
    endcase
  end

  // Accumulate quarter steps into detents; illegal jumps only flag err.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab <= {sA, sB};
      phase   <= '0;
      det_up  <= 1'b0;
      det_dn  <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      err     <= (step == STEP_ILLEGAL);
      det_up  <= 1'b0;
      det_dn  <= 1'b0;
      if (phase_sum == 4'sd4) begin
        det_up <= 1'b1;
        phase  <= '0;
      end else if (phase_sum == -4'sd4) begin
        det_dn <= 1'b1;
        phase  <= '0;
      end else begin
        phase <= phase_sum;
      end
    end
  end

  // Tuning-word stage
  logic [XW-1:0]       step_x;
  logic [XW-1:0]       tw_x;
  logic [XW-1:0]       up_x;
  logic [XW-1:0]       dn_x;
  logic [TW_WIDTH-1:0] tw_up;
  logic [TW_WIDTH-1:0] tw_dn;
  logic [TW_WIDTH-1:0] tw_target;
  logic                tw_load;

  // Saturating up/down targets computed one bit wider so nothing wraps.
  always_comb begin
    step_x    = mode ? COARSE_X : FINE_X;
    tw_x      = {1'b0, tw};
    up_x      = tw_x + step_x;
    dn_x      = tw_x - step_x;
    tw_up     = (up_x > MAX_X) ? MAX_TW : up_x[TW_WIDTH-1:0];
    tw_dn     = ((tw_x < step_x) || (dn_x < MIN_X)) ? MIN_TW : dn_x[TW_WIDTH-1:0];
    tw_target = det_up ? tw_up : tw_dn;
    tw_load   = (det_up || det_dn) && en && (tw_target != tw);
  end

  // Apply a detent to tw; dir tracks every detent even while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      tw       <= RESET_TW;
      tw_valid <= 1'b0;
      dir      <= 1'b0;
    end else begin
      tw_valid <= 1'b0;
      if (det_up || det_dn) begin
        dir <= det_up;
      end
      if (tw_load) begin
        tw       <= tw_target;
        tw_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/enc_tuner.md
ENC_TUNER -- requirements
Module: enc_tuner

Interface
REQ-001 The block SHALL have parameters: TW_WIDTH, default 16, tuning-word width; FILTER_LEN, default 4, glitch-filter stability count in clocks; FINE_STEP, default 1; COARSE_STEP, default 64; TW_MIN, default 1; TW_MAX, default 16'hFFF0; TW_RESET, default 256.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
  clk  input  1  system clock; all state updates on its rising edge
  reset  input  1  synchronous, active-high reset
REQ-003 The block SHALL have these other ports:
  en  input  1  1 = detents modify tw; 0 = tw frozen
  mode  input  1  0 = fine step (FINE_STEP); 1 = coarse step (COARSE_STEP)
  sA  input  1  encoder channel A, already synchronized to clk
  sB  input  1  encoder channel B, already synchronized to clk
  tw  output  TW_WIDTH  tuning word for the downstream NCO multiplier
  tw_valid  output  1  one-cycle pulse when tw takes a new value
  dir  output  1  direction of the last detent: 1 = up, 0 = down
  err  output  1  one-cycle pulse on an illegal quadrature transition

Function
REQ-004 Each channel SHALL be glitch-filtered independently: the filtered value changes only after the raw input differs from it on FILTER_LEN consecutive rising edges; any mismatch run shorter than that is discarded and its counter cleared.
REQ-005 Quadrature decode SHALL compare the filtered {A,B} with its value from the previous cycle: 00->01->11->10->00 is +1, the reverse sequence is -1, no change is 0.
REQ-006 A change of both filtered bits in the same cycle, including both filters updating together, SHALL pulse err for one cycle, leave the phase count unchanged, and be taken as the new previous state.
REQ-007 A signed phase count SHALL accumulate the steps; reaching +4 produces an up-detent and reaching -4 produces a down-detent, and either clears the count to 0. A reversal mid-detent simply counts back.
REQ-008 Pipeline: the filtered value updates at edge k; the phase count, detent flag and err are registered at edge k+1; tw, tw_valid and dir update at edge k+2.
REQ-009 Latency: when a raw input change is first sampled at edge 1 and then held, the filtered value changes at edge FILTER_LEN and tw changes at edge FILTER_LEN+2.
REQ-010 On a detent with en=1, tw SHALL move by the step size chosen by mode as sampled at the tw-update edge: up is min(tw+step, TW_MAX) and down is max(tw-step, TW_MIN). The arithmetic SHALL be done at TW_WIDTH+1 bits so that it cannot wrap.
REQ-011 tw_valid SHALL pulse only when tw actually changes. A detent while saturated at TW_MAX or TW_MIN produces no pulse.
REQ-012 dir SHALL update on every detent regardless of en.
REQ-013 With en=0, filtering, decode, the phase count, dir and err SHALL keep running, while tw holds and tw_valid stays 0. Detents that occur while en=0 are lost and are not replayed when en returns to 1.
REQ-014 tw SHALL be stable between tw_valid pulses, and at most one tw update SHALL occur per detent.

Reset
REQ-015 When reset=1 at a rising edge: tw=TW_RESET; tw_valid=0; dir=0; err=0; phase count=0; filter counters=0.
REQ-016 On that same edge the filtered state and the previous state SHALL load the current raw {sA,sB}, so that leaving reset never produces a spurious step or err.
REQ-017 Reset asserted mid-detent or mid-filter SHALL discard all partial progress.
REQ-018 Reset SHALL take priority over all other inputs.

Structure
REQ-019 The shared package enc_tuner_pkg SHALL hold the default values of TW_WIDTH, FILTER_LEN, FINE_STEP, COARSE_STEP, TW_MIN, TW_MAX and TW_RESET, plus the 2-bit Gray-state constants.
REQ-020 The single-channel filter SHALL be the sub-module enc_glitch_filter (ports clk, reset, raw, filt), instantiated once for A and once for B.
REQ-021 Quadrature decode, the detent counter and the tw register SHALL reside in enc_tuner itself.

Verification
REQ-022 Rotation up: with en=1 and mode=0, drive one full CW cycle 00->01->11->10->00, each state held for 10 clocks -> tw goes 256->257, one tw_valid pulse, dir=1, arriving at edge 6 after the final 10->00 change.
REQ-023 Coarse down with saturation: set tw=65 via fine steps, then with mode=1 apply two CCW detents -> tw 65->1, then stays 1 with no tw_valid on the second detent.
REQ-024 Glitch rejection: 3-clock pulses on sA -> no phase change and no err; a 4-clock hold -> the filtered value changes.
REQ-025 Illegal transition: filtered {A,B} jumps 00->11 -> one err pulse, tw unchanged; a following legal CW cycle from 11 gives exactly one detent.
REQ-026 en gating and reset: a CW detent with en=0 -> dir=1, tw unchanged, no tw_valid; after two quarter-steps, assert reset with sA=sB=1 -> tw=256, no err, and the next full CW cycle yields exactly one +1.
